// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: E-stage mult/div sequencer owning HI/LO and the MD stall; define MDU_MADD_EN to enable madd (MDOp=9)
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MDUse_D,
  output logic        Busy,
  output logic        Stall_MD,
  output logic [31:0] MDOUT,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);
  typedef enum logic {IDLE, RUN} state_t;
  state_t st, st_n;
  logic [3:0] cnt;
  logic [63:0] res_q, res, ps, pu;
  logic wr_q, is_madd, is_mul, is_div, is_md, start_md, dz, neg_q, neg_r;
  logic [31:0] da, db, q, r;
`ifdef MDU_MADD_EN
  assign is_madd = MDOp == 4'd9;
`else
  assign is_madd = 1'b0;
`endif
  assign is_mul   = MDOp == 4'd1 || MDOp == 4'd2 || is_madd;
  assign is_div   = MDOp == 4'd3 || MDOp == 4'd4;
  assign is_md    = is_mul || is_div;
  assign start_md = Start && is_md && st == IDLE;
  assign dz       = is_div && B == '0;
  // Signed divide runs on magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0
  assign ps    = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign pu    = {32'b0, A} * {32'b0, B};
  assign da    = (MDOp == 4'd3 && A[31]) ? -A : A;
  assign db    = (MDOp == 4'd3 && B[31]) ? -B : B;
  assign q     = db == '0 ? '0 : da / db;
  assign r     = db == '0 ? '0 : da % db;
  assign neg_q = MDOp == 4'd3 && (A[31] ^ B[31]);
  assign neg_r = MDOp == 4'd3 && A[31];
  assign res   = MDOp == 4'd1 ? ps :
                 MDOp == 4'd2 ? pu :
                 is_div       ? {neg_r ? -r : r, neg_q ? -q : q} :
                                {HI, LO} + ps;
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= IDLE;
    else        st <= st_n;
  always_comb
    st_n = st == IDLE ? (start_md ? RUN : IDLE) : (cnt == 4'd1 ? IDLE : RUN);
  always_comb begin
    Busy     = st == RUN;
    Stall_MD = MDUse_D && (Busy || (Start && is_md));
    MDOUT    = MDOp == 4'd5 ? HI : MDOp == 4'd6 ? LO : '0;
  end
  // Result is captured at the start edge; HI/LO only move when the count expires
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt   <= '0;
      res_q <= '0;
      wr_q  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else if (st == IDLE) begin
      if (start_md) begin
        cnt   <= is_div ? DC : MC;
        res_q <= res;
        wr_q  <= !dz;
      end else if (Start && MDOp == 4'd7) HI <= A;
      else if (Start && MDOp == 4'd8) LO <= A;
    end else begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1 && wr_q) {HI, LO} <= res_q;
    end
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: randomized check of md_unit_ctrl against an arithmetic HI/LO model
module tb_md_unit_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, Start = 1'b0, MDUse_D = 1'b0;
  logic [3:0] MDOp = '0;
  logic [31:0] A = '0, B = '0;
  logic Busy, Stall_MD;
  logic [31:0] MDOUT, HI, LO;
  logic [31:0] m_hi = '0, m_lo = '0;
  int n_tests = 0, n_fail = 0;

  md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .MDUse_D(MDUse_D), .Busy(Busy), .Stall_MD(Stall_MD), .MDOUT(MDOUT),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit md_op(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd4) || (MADD && op == 4'd9);
  endfunction

  function automatic int lat(input logic [3:0] op);
    return (op == 4'd3 || op == 4'd4) ? DC : MC;
  endfunction

  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    p  = longint'(sa) * longint'(sb);
    if (op == 4'd1) {m_hi, m_lo} = p;
    else if (op == 4'd2) {m_hi, m_lo} = longint'(a) * longint'(b);
    else if (op == 4'd3 && b != 0) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        m_lo = a;
        m_hi = '0;
      end else begin
        m_lo = sa / sb;
        m_hi = sa % sb;
      end
    end else if (op == 4'd4 && b != 0) begin
      m_lo = a / b;
      m_hi = a % b;
    end else if (op == 4'd7) m_hi = a;
    else if (op == 4'd8) m_lo = a;
    else if (op == 4'd9 && MADD) {m_hi, m_lo} = {m_hi, m_lo} + p;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ud, input bit poke);
    logic [63:0] held;
    int n;
    held = {m_hi, m_lo};
    Start = 1'b1; MDOp = op; A = a; B = b; MDUse_D = ud;
    #1;
    check("stall_t0", Stall_MD, ud & md_op(op));
    check("mdout", MDOUT, op == 4'd5 ? m_hi : op == 4'd6 ? m_lo : 32'd0);
    @(posedge clk); #1;
    Start = 1'b0; MDOp = '0;
    n = 0;
    while (Busy && n < 40) begin
      check("stall_run", Stall_MD, ud);
      check("hold_run", {HI, LO}, held);
      if (poke) begin
        Start = 1'b1; MDOp = 4'($urandom_range(0, 15)); A = $urandom; B = $urandom;
      end
      n++;
      @(posedge clk); #1;
    end
    Start = 1'b0; MDOp = '0;
    #1;
    check("busy_len", 64'(n), 64'(md_op(op) ? lat(op) : 0));
    check("stall_end", Stall_MD, 1'b0);
    model(op, a, b);
    check("hi", HI, m_hi);
    check("lo", LO, m_lo);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [3:0] rop;
    MDUse_D = 1'b1;
    #12;
    check("rst_busy", Busy, 1'b0);
    check("rst_stall", Stall_MD, 1'b0);
    check("rst_hilo", {HI, LO}, 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    do_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    check("tp1", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
    do_op(4'd4, 32'd100, 32'd7, 1'b0, 1'b0);
    check("tp2_divu", {HI, LO}, {32'd2, 32'd14});
    do_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
    check("tp2_div", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(4'd7, 32'h12345678, 32'd0, 1'b0, 1'b0);
    do_op(4'd3, 32'd55, 32'd0, 1'b0, 1'b1);
    check("tp3_dz", {HI, LO}, 64'h12345678_FFFFFFFD);
    do_op(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    Start = 1'b1; MDOp = 4'd5; #1;
    check("tp3_mfhi", MDOUT, 32'h12345678);
    Start = 1'b0; MDOp = '0;
    do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("div_ovf", {HI, LO}, 64'h00000000_80000000);
    do_op(4'd2, $urandom, $urandom, 1'b1, 1'b0);
    Start = 1'b1; MDOp = 4'd1; A = 32'd9; B = 32'd9; MDUse_D = 1'b0;
    @(posedge clk); #1;
    Start = 1'b0; MDOp = '0;
    repeat (2) @(posedge clk);
    #1;
    check("tp5_busy", Busy, 1'b1);
    reset = 1'b0;
    #1;
    check("tp5_rst", {31'd0, Busy, HI, LO}, 96'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    do_op(4'd8, 32'd5, 32'd0, 1'b0, 1'b0);
    check("tp5_mtlo", LO, 32'd5);
    do_op(4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    do_op(4'd8, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);
    do_op(4'd9, 32'd1, 32'd1, 1'b1, 1'b0);
    check("tp6_madd", {HI, LO}, MADD ? 64'h00000001_00000000 : 64'h00000000_FFFFFFFF);
    for (int i = 0; i < 200; i++) begin
      rop = 4'($urandom_range(0, 15));
      if (($urandom & 1) == 0) rop = 4'($urandom_range(1, 4));
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      rb = $urandom_range(0, 7) == 0 ? 32'd0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 15) == 0) rb = 32'hFFFFFFFF;
      do_op(rop, ra, rb, 1'($urandom), 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
